prog_seq: RTL and testbench

Program-fetch sequencer for the picoMIPS core. It owns the program counter that drives the `address` input of the program memory and decides every cycle whether the next instruction is sequential, a relative branch or an absolute jump. It stalls the core on input-wait instructions until a synchronised button press arrives, and it stops the core on a halt request. A saturating retired-instruction counter is included for debug.

---
 rtl/prog_seq.sv | 112 +++++++++++
 tb/tb_prog_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/prog_seq.sv
// rtl/prog_seq.sv - program-fetch sequencer with go synchroniser and retired-instruction counter
module prog_seq #(
  parameter int Psize = 6,
  parameter int Csize = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_en,
  input  logic             wait_req,
  input  logic             go,
  input  logic             halt_req,
  input  logic             jump_en,
  input  logic [Psize-1:0] jump_addr,
  input  logic             branch_en,
  input  logic [Psize-1:0] branch_off,
  output logic [Psize-1:0] address,
  output logic             instr_valid,
  output logic             input_strobe,
  output logic [1:0]       state,
  output logic [Csize-1:0] instr_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_WAIT = 2'b10,
    S_HALT = 2'b11
  } state_t;

  localparam logic [Csize-1:0] CMAX = '1;

  state_t cur;
  logic   sync1, sync2, sync3;
  logic   go_edge;
  logic   retire;

  assign go_edge     = sync2 & ~sync3;
  assign instr_valid = (cur == S_RUN);
  assign state       = cur;

  // two-flop synchroniser for the raw go pin, third flop for rising-edge detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= go;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // an instruction retires when it completes in RUN or when a stalled input instruction is released
  always_comb begin
    retire = 1'b0;
    if (cur == S_RUN)
      retire = !halt_req && !wait_req;
    else if (cur == S_WAIT)
      retire = go_edge;
  end

  // sequencer state, program counter and input strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur          <= S_IDLE;
      address      <= '0;
      input_strobe <= 1'b0;
    end else begin
      input_strobe <= 1'b0;
      case (cur)
        S_IDLE: begin
          address <= '0;
          if (run_en)
            cur <= S_RUN;
        end
        S_RUN: begin
          if (halt_req)
            cur <= S_HALT;
          else if (wait_req)
            cur <= S_WAIT;
          else if (jump_en)
            address <= jump_addr;
          else if (branch_en)
            address <= address + branch_off;
          else
            address <= address + Psize'(1);
        end
        S_WAIT: begin
          // only a fresh edge seen while stalled releases the wait
          if (go_edge) begin
            cur          <= S_RUN;
            address      <= address + Psize'(1);
            input_strobe <= 1'b1;
          end
        end
        default: begin
          cur <= S_HALT;
        end
      endcase
    end
  end

  // saturating retired-instruction counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      instr_count <= '0;
    else if (retire && instr_count != CMAX)
      instr_count <= instr_count + Csize'(1);
  end

endmodule

// File: tb/tb_prog_seq.sv
// tb/tb_prog_seq.sv - scoreboard testbench for prog_seq
module tb_prog_seq;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_WAIT = 2'b10;
  localparam logic [1:0] ST_HALT = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_en, wait_req, go, halt_req, jump_en, branch_en;
  logic [5:0]  jump_addr, branch_off;
  logic [5:0]  address, address4;
  logic        instr_valid, instr_valid4;
  logic        input_strobe, input_strobe4;
  logic [1:0]  state, state4;
  logic [15:0] instr_count;
  logic [3:0]  instr_count4;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [5:0]  addr;
    logic [1:0]  st;
    logic [15:0] cnt;
    logic        strobe;
  } exp_t;

  exp_t sb[$];

  prog_seq #(.Psize(6), .Csize(16)) u_dut (
    .clk(clk), .reset(reset), .run_en(run_en), .wait_req(wait_req), .go(go),
    .halt_req(halt_req), .jump_en(jump_en), .jump_addr(jump_addr),
    .branch_en(branch_en), .branch_off(branch_off), .address(address),
    .instr_valid(instr_valid), .input_strobe(input_strobe), .state(state),
    .instr_count(instr_count)
  );

  prog_seq #(.Psize(6), .Csize(4)) u_dut4 (
    .clk(clk), .reset(reset), .run_en(run_en), .wait_req(wait_req), .go(go),
    .halt_req(halt_req), .jump_en(jump_en), .jump_addr(jump_addr),
    .branch_en(branch_en), .branch_off(branch_off), .address(address4),
    .instr_valid(instr_valid4), .input_strobe(input_strobe4), .state(state4),
    .instr_count(instr_count4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // push the expectation for the coming edge, then pop and compare once the DUT has updated
  task automatic step(input logic [5:0] ea, input logic [1:0] es, input logic [15:0] ec,
                      input logic estr);
    exp_t e;
    exp_t got;
    e.addr = ea; e.st = es; e.cnt = ec; e.strobe = estr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("address", {26'd0, address}, {26'd0, got.addr});
    check("state", {30'd0, state}, {30'd0, got.st});
    check("count", {16'd0, instr_count}, {16'd0, got.cnt});
    check("strobe", {31'd0, input_strobe}, {31'd0, got.strobe});
    check("valid", {31'd0, instr_valid}, {31'd0, (got.st == ST_RUN)});
    check("count4", {28'd0, instr_count4}, (got.cnt > 16'd15) ? 32'd15 : {16'd0, got.cnt});
  endtask

  initial begin
    run_en = 0; wait_req = 0; go = 0; halt_req = 0; jump_en = 0; branch_en = 0;
    jump_addr = '0; branch_off = '0;
    reset = 1'b0;
    #12;
    check("rst_state", {30'd0, state}, {30'd0, ST_IDLE});
    check("rst_address", {26'd0, address}, 32'd0);
    check("rst_count", {16'd0, instr_count}, 32'd0);
    check("rst_strobe", {31'd0, input_strobe}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);

    @(negedge clk);
    reset = 1'b1;
    step(6'd0, ST_IDLE, 16'd0, 1'b0);
    run_en = 1'b1;
    step(6'd0, ST_RUN, 16'd0, 1'b0);

    // sequential fetch across the address wrap
    for (int i = 0; i < 70; i++)
      step(6'((i + 1) % 64), ST_RUN, 16'(i + 1), 1'b0);
    check("sat_count4", {28'd0, instr_count4}, 32'd15);

    go = 1'b1;
    for (int i = 0; i < 4; i++)
      step(6'(7 + i), ST_RUN, 16'(71 + i), 1'b0);

    // relative branch backwards by 4
    branch_en = 1'b1; branch_off = 6'h3C;
    step(6'd6, ST_RUN, 16'd75, 1'b0);

    // jump beats branch
    jump_en = 1'b1; jump_addr = 6'd40;
    step(6'd40, ST_RUN, 16'd76, 1'b0);
    branch_en = 1'b0;
    jump_addr = 6'd5;
    step(6'd5, ST_RUN, 16'd77, 1'b0);
    jump_en = 1'b0;

    // stall with go already high: no release
    wait_req = 1'b1;
    for (int i = 0; i < 4; i++)
      step(6'd5, ST_WAIT, 16'd77, 1'b0);
    go = 1'b0;
    for (int i = 0; i < 3; i++)
      step(6'd5, ST_WAIT, 16'd77, 1'b0);

    // fresh rising edge releases after two synchroniser cycles
    go = 1'b1;
    step(6'd5, ST_WAIT, 16'd77, 1'b0);
    step(6'd5, ST_WAIT, 16'd77, 1'b0);
    wait_req = 1'b0;
    step(6'd6, ST_RUN, 16'd78, 1'b1);
    step(6'd7, ST_RUN, 16'd79, 1'b0);

    jump_en = 1'b1; jump_addr = 6'd20;
    step(6'd20, ST_RUN, 16'd80, 1'b0);
    jump_en = 1'b0;

    // halt beats wait and is sticky
    halt_req = 1'b1; wait_req = 1'b1;
    step(6'd20, ST_HALT, 16'd80, 1'b0);
    halt_req = 1'b0; wait_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      go = i[0];
      run_en = ~i[0];
      jump_en = i[1];
      step(6'd20, ST_HALT, 16'd80, 1'b0);
    end
    jump_en = 1'b0; go = 1'b0; run_en = 1'b0;

    // restart, then asynchronous reset in the middle of a WAIT cycle
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_en = 1'b1;
    step(6'd0, ST_RUN, 16'd0, 1'b0);
    step(6'd1, ST_RUN, 16'd1, 1'b0);
    step(6'd2, ST_RUN, 16'd2, 1'b0);
    wait_req = 1'b1;
    step(6'd2, ST_WAIT, 16'd2, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("async_state", {30'd0, state}, {30'd0, ST_IDLE});
    check("async_address", {26'd0, address}, 32'd0);
    check("async_count", {16'd0, instr_count}, 32'd0);
    check("async_count4", {28'd0, instr_count4}, 32'd0);
    check("async_valid", {31'd0, instr_valid}, 32'd0);
    check("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
